wb_commit: RTL

WB_COMMIT -- requirements
Module: wb_commit

---
 rtl/wb_commit.sv | 102 ++++++++++
 1 files changed

// File: rtl/wb_commit.sv
// wb_commit -- write-back commit stage: the architectural GPR file, the HI/LO
// pair and the LLbit flop, with two combinational read ports.
//
// Ports
//   clk                 rising-edge clock for all state
//   rst                 asynchronous active-low reset; clears GPRs, HI, LO, LLbit
//   wb_wd/wb_wreg/wb_wdata        GPR write address / enable / data from MEM/WB
//   wb_hi/wb_lo/wb_whilo          HI/LO write data and a shared write enable
//   wb_LLbit_we/wb_LLbit_value    LLbit write enable and value
//   flush               exception flush; clears LLbit, does not block writes
//   re1/raddr1/rdata1   read port 1 (enable, address, combinational data)
//   re2/raddr2/rdata2   read port 2 (enable, address, combinational data)
//   hi_o/lo_o/LLbit_o   registered HI, LO and LLbit contents
module wb_commit (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  wb_wd,
    input  logic        wb_wreg,
    input  logic [31:0] wb_wdata,
    input  logic [31:0] wb_hi,
    input  logic [31:0] wb_lo,
    input  logic        wb_whilo,
    input  logic        wb_LLbit_we,
    input  logic        wb_LLbit_value,
    input  logic        flush,
    input  logic        re1,
    input  logic        re2,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        LLbit_o
);

    logic [31:0] gpr [0:31];
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        llbit_q;

    // gpr[0] is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                gpr[i] <= '0;
            end
        end else if (wb_wreg && (wb_wd != 5'd0)) begin
            gpr[wb_wd] <= wb_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (wb_whilo) begin
            hi_q <= wb_hi;
            lo_q <= wb_lo;
        end
    end

    // A flush kills any pending link, even one being set by the committing op.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            llbit_q <= 1'b0;
        end else if (flush) begin
            llbit_q <= 1'b0;
        end else if (wb_LLbit_we) begin
            llbit_q <= wb_LLbit_value;
        end
    end

    // Read ports: r0 is hard zero, then write-through bypass, then the array.
    // The bypass stays live during reset; only the stored values are cleared.
    always_comb begin
        rdata1 = '0;
        if (raddr1 == 5'd0) begin
            rdata1 = '0;
        end else if (re1 && wb_wreg && (raddr1 == wb_wd)) begin
            rdata1 = wb_wdata;
        end else if (re1) begin
            rdata1 = gpr[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (raddr2 == 5'd0) begin
            rdata2 = '0;
        end else if (re2 && wb_wreg && (raddr2 == wb_wd)) begin
            rdata2 = wb_wdata;
        end else if (re2) begin
            rdata2 = gpr[raddr2];
        end
    end

    assign hi_o    = hi_q;
    assign lo_o    = lo_q;
    assign LLbit_o = llbit_q;

endmodule
